// File: rtl/alarm_controller.sv
// Alarm controller: compares the alarm time with the digital clock and runs a
// ring / snooze / auto-off state machine paced by one-second ticks.
module alarm_controller #(
  parameter int SNOOZE_SEC  = 300,
  parameter int RING_SEC    = 60,
  parameter int MAX_SNOOZES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [3:0] hours,
  input  logic       set_alarm,
  input  logic [3:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       stop,
  output logic       buzzer,
  output logic [1:0] state,
  output logic [1:0] snooze_count,
  output logic [3:0] alarm_hours,
  output logic [5:0] alarm_minutes
);

  localparam int RING_W   = $clog2(RING_SEC + 1);
  localparam int SNOOZE_W = $clog2(SNOOZE_SEC + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_buzzer;
  logic [1:0]          r_snooze_count;
  logic [3:0]          r_alarm_hours;
  logic [5:0]          r_alarm_minutes;
  logic [RING_W-1:0]   r_ring_timer;
  logic [SNOOZE_W-1:0] r_snooze_timer;
  logic [5:0]          r_seconds_prev;

  logic w_sec_tick;
  logic w_match;
  logic w_set_valid;

  assign w_sec_tick  = (seconds != r_seconds_prev);
  // Only the tick on which seconds becomes 0 can match, so a held 0 never re-rings.
  assign w_match     = w_sec_tick && (seconds == 6'd0) &&
                       (hours == r_alarm_hours) && (minutes == r_alarm_minutes);
  assign w_set_valid = set_alarm && (set_hours <= 4'd11) && (set_minutes <= 6'd59);

  // NOTE: all state is updated with non-blocking assignments so every branch
  // reads the pre-edge values of the registers, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_buzzer        <= 1'b0;
      r_snooze_count  <= 2'd0;
      r_alarm_hours   <= 4'd0;
      r_alarm_minutes <= 6'd0;
      r_ring_timer    <= '0;
      r_snooze_timer  <= '0;
      r_seconds_prev  <= 6'd0;
    end else begin
      r_seconds_prev <= seconds;
      if (w_set_valid) begin
        r_alarm_hours   <= set_hours;
        r_alarm_minutes <= set_minutes;
        r_state         <= ST_IDLE;
        r_buzzer        <= 1'b0;
        r_snooze_count  <= 2'd0;
        r_ring_timer    <= '0;
        r_snooze_timer  <= '0;
      end else if (!alarm_en) begin
        r_state        <= ST_IDLE;
        r_buzzer       <= 1'b0;
        r_snooze_count <= 2'd0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_match) begin
              r_state        <= ST_RINGING;
              r_buzzer       <= 1'b1;
              r_ring_timer   <= RING_W'(RING_SEC);
              r_snooze_count <= 2'd0;
            end
          end
          ST_RINGING: begin
            if (stop) begin
              r_state        <= ST_IDLE;
              r_buzzer       <= 1'b0;
              r_snooze_count <= 2'd0;
            end else if (snooze && (r_snooze_count < 2'(MAX_SNOOZES))) begin
              r_state        <= ST_SNOOZE;
              r_buzzer       <= 1'b0;
              r_snooze_count <= r_snooze_count + 2'd1;
              r_snooze_timer <= SNOOZE_W'(SNOOZE_SEC);
            end else if (w_sec_tick) begin
              // Leaving on the tick that would reach 0 keeps the timer from underflowing.
              if (r_ring_timer <= RING_W'(1)) begin
                r_state        <= ST_IDLE;
                r_buzzer       <= 1'b0;
                r_snooze_count <= 2'd0;
                r_ring_timer   <= '0;
              end else begin
                r_ring_timer <= r_ring_timer - RING_W'(1);
              end
            end
          end
          ST_SNOOZE: begin
            if (stop) begin
              r_state        <= ST_IDLE;
              r_buzzer       <= 1'b0;
              r_snooze_count <= 2'd0;
            end else if (w_sec_tick) begin
              if (r_snooze_timer <= SNOOZE_W'(1)) begin
                r_state        <= ST_RINGING;
                r_buzzer       <= 1'b1;
                r_snooze_timer <= '0;
                r_ring_timer   <= RING_W'(RING_SEC);
              end else begin
                r_snooze_timer <= r_snooze_timer - SNOOZE_W'(1);
              end
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            r_buzzer <= 1'b0;
          end
        endcase
      end
    end
  end

  assign buzzer        = r_buzzer;
  assign state         = r_state;
  assign snooze_count  = r_snooze_count;
  assign alarm_hours   = r_alarm_hours;
  assign alarm_minutes = r_alarm_minutes;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed self-checking bench for alarm_controller: ring on match, snooze,
// snooze limit, auto-off, invalid set, enable drop and reset mid-snooze.
module tb_alarm_controller;

  localparam int RING_SEC   = 60;
  localparam int SNOOZE_SEC = 300;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [3:0] hours;
  logic       set_alarm;
  logic [3:0] set_hours;
  logic [5:0] set_minutes;
  logic       alarm_en;
  logic       snooze;
  logic       stop;
  logic       buzzer;
  logic [1:0] state;
  logic [1:0] snooze_count;
  logic [3:0] alarm_hours;
  logic [5:0] alarm_minutes;

  int n_checks = 0;
  int n_fail   = 0;

  alarm_controller #(
    .SNOOZE_SEC (SNOOZE_SEC),
    .RING_SEC   (RING_SEC),
    .MAX_SNOOZES(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .seconds      (seconds),
    .minutes      (minutes),
    .hours        (hours),
    .set_alarm    (set_alarm),
    .set_hours    (set_hours),
    .set_minutes  (set_minutes),
    .alarm_en     (alarm_en),
    .snooze       (snooze),
    .stop         (stop),
    .buzzer       (buzzer),
    .state        (state),
    .snooze_count (snooze_count),
    .alarm_hours  (alarm_hours),
    .alarm_minutes(alarm_minutes)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hours   = 4'(h);
    minutes = 6'(m);
    seconds = 6'(s);
    step(1);
  endtask

  // One second tick that never lands on seconds==0.
  task automatic tick();
    seconds = (seconds == 6'd30) ? 6'd31 : 6'd30;
    step(2);
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1;
    step(1);
    snooze = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  // Drives 1:01:59 then 1:02:00 so the alarm set to 1:02 matches.
  task automatic ring_at_0102();
    set_time(1, 1, 59);
    set_time(1, 2, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; seconds = '0; minutes = '0; hours = '0;
    set_alarm = 1'b0; set_hours = '0; set_minutes = '0;
    alarm_en = 1'b0; snooze = 1'b0; stop = 1'b0;
    step(2);
    check("rst_state",   state,         0);
    check("rst_buzzer",  buzzer,        0);
    check("rst_count",   snooze_count,  0);
    check("rst_alarm_h", alarm_hours,   0);
    check("rst_alarm_m", alarm_minutes, 0);
    rst = 1'b0;

    // Load alarm 1:02 and arm.
    set_alarm = 1'b1; set_hours = 4'd1; set_minutes = 6'd2;
    step(1);
    set_alarm = 1'b0;
    check("set_alarm_h", alarm_hours,   1);
    check("set_alarm_m", alarm_minutes, 2);
    alarm_en = 1'b1;

    set_time(1, 1, 59);
    check("pre_match_state", state, 0);
    set_time(1, 2, 0);
    check("match_state",  state,  1);
    check("match_buzzer", buzzer, 1);
    pulse_stop();
    check("stop_state", state, 0);
    step(10);
    check("held0_state",  state,  0);
    check("held0_buzzer", buzzer, 0);

    // Snooze once and let the snooze timer run out.
    ring_at_0102();
    check("ring2_state", state, 1);
    pulse_snooze();
    check("snz1_state",  state,        2);
    check("snz1_buzzer", buzzer,       0);
    check("snz1_count",  snooze_count, 1);
    repeat (SNOOZE_SEC - 1) tick();
    check("snz1_299_state", state, 2);
    tick();
    check("snz1_wake_state",  state,  1);
    check("snz1_wake_buzzer", buzzer, 1);

    // Two more snoozes reach the limit; the fourth is ignored.
    pulse_snooze();
    check("snz2_count", snooze_count, 2);
    repeat (SNOOZE_SEC) tick();
    check("snz2_wake_state", state, 1);
    pulse_snooze();
    check("snz3_count", snooze_count, 3);
    repeat (SNOOZE_SEC) tick();
    check("snz3_wake_state", state, 1);
    pulse_snooze();
    check("snz4_state", state,        1);
    check("snz4_count", snooze_count, 3);
    pulse_stop();
    check("stop_after_snz_state", state,        0);
    check("stop_after_snz_count", snooze_count, 0);

    // Ring auto-off after RING_SEC ticks.
    ring_at_0102();
    check("ring3_state", state, 1);
    repeat (RING_SEC - 1) tick();
    check("ring_59_state", state, 1);
    tick();
    check("timeout_state",  state,  0);
    check("timeout_buzzer", buzzer, 0);

    // Out-of-range set_alarm while ringing changes nothing.
    ring_at_0102();
    set_alarm = 1'b1; set_hours = 4'd5; set_minutes = 6'd60;
    step(1);
    set_alarm = 1'b0;
    check("bad_set_alarm_h", alarm_hours,   1);
    check("bad_set_alarm_m", alarm_minutes, 2);
    check("bad_set_state",   state,         1);
    alarm_en = 1'b0;
    step(1);
    check("en_drop_state",  state,  0);
    check("en_drop_buzzer", buzzer, 0);
    alarm_en = 1'b1;

    // Stop outranks snooze when both arrive together.
    ring_at_0102();
    stop = 1'b1; snooze = 1'b1;
    step(1);
    stop = 1'b0; snooze = 1'b0;
    check("stop_vs_snz_state", state,        0);
    check("stop_vs_snz_count", snooze_count, 0);

    // Reset mid-snooze, then no ring at 0:00:00 until re-armed.
    ring_at_0102();
    pulse_snooze();
    check("pre_rst_state", state, 2);
    rst = 1'b1; alarm_en = 1'b0;
    step(1);
    rst = 1'b0;
    check("midsnz_rst_state",   state,         0);
    check("midsnz_rst_buzzer",  buzzer,        0);
    check("midsnz_rst_count",   snooze_count,  0);
    check("midsnz_rst_alarm_h", alarm_hours,   0);
    check("midsnz_rst_alarm_m", alarm_minutes, 0);
    set_time(11, 59, 59);
    set_time(0, 0, 0);
    step(1);
    check("noarm_midnight_state",  state,  0);
    check("noarm_midnight_buzzer", buzzer, 0);
    alarm_en = 1'b1;
    set_time(11, 59, 59);
    set_time(0, 0, 0);
    check("rearm_midnight_state", state, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
